// File: rtl/mem_port_arbiter.sv
// Arbitrates the inst and data masters onto one split-transaction memory port;
// an in-order ID queue routes each data_ok back to the master that issued it.
module mem_port_arbiter #(
    parameter int OT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inst_req,
    input  logic                       inst_wr,
    input  logic [1:0]                 inst_size,
    input  logic [3:0]                 inst_wstrb,
    input  logic [31:0]                inst_addr,
    input  logic [31:0]                inst_wdata,
    output logic                       inst_addr_ok,
    output logic                       inst_data_ok,
    output logic [31:0]                inst_rdata,
    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [3:0]                 data_wstrb,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    output logic [31:0]                data_rdata,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [1:0]                 mem_size,
    output logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_addr_ok,
    input  logic                       mem_data_ok,
    input  logic [31:0]                mem_rdata,
    output logic [$clog2(OT_DEPTH):0]  ot_cnt
);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    logic                grant;
    logic                rst_q;
    logic [OT_DEPTH-1:0] id_q;
    logic [PW-1:0]       wptr, rptr;
    logic                blk, full, sel, push, pop, head;

    // Handshakes stay quiet during reset and for the cycle right after it.
    assign blk  = reset | rst_q;
    assign full = (ot_cnt == CW'(OT_DEPTH));
    assign sel  = (state == HOLD) ? grant : data_req;

    assign mem_req = ~blk & ((state == HOLD) | ((inst_req | data_req) & ~full));
    assign push    = mem_req & mem_addr_ok;
    assign pop     = ~blk & mem_data_ok & (ot_cnt != '0);
    assign head    = id_q[rptr];

    assign mem_wr    = sel ? data_wr    : inst_wr;
    assign mem_size  = sel ? data_size  : inst_size;
    assign mem_wstrb = sel ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel ? data_addr  : inst_addr;
    assign mem_wdata = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = push & ~sel;
    assign data_addr_ok = push & sel;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            state  <= IDLE;
            grant  <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            ot_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (mem_req & ~mem_addr_ok) begin
                    grant <= sel;
                    state <= HOLD;
                end
                HOLD: if (mem_addr_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (push) begin
                id_q[wptr] <= sel;
                wptr       <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push & ~pop)      ot_cnt <= ot_cnt + 1'b1;
            else if (pop & ~push) ot_cnt <= ot_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: behavioural memory/master model feeds a response scoreboard
// that an independent monitor drains whenever the DUT raises a data_ok.
module tb_mem_port_arbiter;
    localparam int OT_DEPTH = 4;

    logic        clk = 0, reset = 1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 2, data_size = 2;
    logic [3:0]  inst_wstrb = 0, data_wstrb = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 0, mem_data_ok = 0;
    logic [31:0] mem_rdata = 0;
    logic [$clog2(OT_DEPTH):0] ot_cnt;

    mem_port_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .ot_cnt(ot_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } rsp_t;

    int          total = 0, bad = 0;
    rsp_t        sb[$];
    logic [31:0] memq[$];
    int          cnt = 0;
    int          hold = -1;
    bit          inst_acc = 0, data_acc = 0;
    logic [15:0] seq = 0;

    function automatic logic [31:0] rd_of(logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every data_ok must match the oldest outstanding accepted request.
    always @(negedge clk) begin
        if (!reset && (inst_data_ok || data_data_ok)) begin
            rsp_t r;
            chk("dual_data_ok", 32'(inst_data_ok & data_data_ok), 0);
            if (sb.size() == 0) chk("spurious_data_ok", 1, 0);
            else begin
                r = sb.pop_front();
                chk("rsp_id", 32'(data_data_ok), 32'(r.id));
                chk("rsp_rdata", data_data_ok ? data_rdata : inst_rdata, r.rdata);
            end
        end
    end

    task automatic step(int pi, int pd, int paok, int pdok, bit stray);
        bit exp_req, exp_sel, acc, pop;
        @(posedge clk); #1;
        if (inst_acc) inst_req = 0;
        if (data_acc) data_req = 0;
        inst_acc = 0; data_acc = 0;
        if (!inst_req && $urandom_range(0, 99) < pi) begin
            inst_req = 1; inst_wr = 0; inst_size = 2; inst_wstrb = 0;
            inst_addr = {16'h1c00, seq}; inst_wdata = $urandom; seq++;
        end
        if (!data_req && $urandom_range(0, 99) < pd) begin
            data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom); data_addr = {16'h8000, seq}; data_wdata = $urandom; seq++;
        end
        mem_addr_ok = $urandom_range(0, 99) < paok;
        mem_data_ok = (memq.size() > 0 && $urandom_range(0, 99) < pdok) || (stray && memq.size() == 0);
        mem_rdata   = (memq.size() > 0) ? memq[0] : $urandom;
        @(negedge clk);
        exp_req = (hold >= 0) || ((inst_req || data_req) && cnt < OT_DEPTH);
        exp_sel = (hold >= 0) ? hold[0] : data_req;
        acc     = exp_req && mem_addr_ok;
        pop     = mem_data_ok && cnt > 0;
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("ot_cnt", 32'(ot_cnt), cnt);
        if (exp_req) begin
            chk("mem_addr", mem_addr, exp_sel ? data_addr : inst_addr);
            chk("mem_wr", 32'(mem_wr), 32'(exp_sel ? data_wr : inst_wr));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_sel ? data_wstrb : inst_wstrb));
        end
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !exp_sel));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(acc && exp_sel));
        chk("any_data_ok", 32'(inst_data_ok | data_data_ok), 32'(pop));
        if (pop) begin
            void'(memq.pop_front());
            cnt--;
        end
        if (acc) begin
            memq.push_back(rd_of(mem_addr));
            sb.push_back('{id: exp_sel, rdata: rd_of(exp_sel ? data_addr : inst_addr)});
            cnt++;
            if (exp_sel) data_acc = 1; else inst_acc = 1;
        end
        hold = (exp_req && !acc) ? int'(exp_sel) : -1;
    endtask

    task automatic run(int n, int pi, int pd, int paok, int pdok, bit stray);
        for (int i = 0; i < n; i++) step(pi, pd, paok, pdok, stray);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk);
        chk("rst_quiet", 32'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_rst_quiet", 32'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 0);
        chk("post_rst_ot_cnt", 32'(ot_cnt), 0);
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        sb.delete(); memq.delete();
        cnt = 0; hold = -1; inst_acc = 0; data_acc = 0;
    endtask

    initial begin
        do_reset();
        run(20, 100, 0, 100, 50, 0);     // inst-only traffic
        run(10, 100, 100, 100, 0, 0);    // fill to OT_DEPTH, issue must stall
        run(3, 0, 0, 100, 100, 0);       // drain
        run(30, 60, 60, 100, 100, 0);    // concurrent push/pop
        run(1500, 40, 40, 50, 40, 0);    // mixed random with HOLD
        run(300, 70, 70, 25, 70, 0);     // heavy contention, slow accept
        run(6, 100, 100, 100, 0, 0);     // build up outstanding
        do_reset();
        run(5, 0, 0, 100, 100, 1);       // stray data_ok must be ignored
        run(200, 50, 50, 60, 60, 0);
        run(40, 0, 0, 100, 100, 0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester.
- Uses the req / addr_ok / data_ok split-transaction handshake on all three sides.
- Tracks every accepted request in an in-order ID queue so each response returns to the master that issued it.
- Sits between the pipeline front/back ends and the memory-side bridge.

Parameters:
- OT_DEPTH, 4, maximum in-flight accepted requests awaiting data_ok; power of 2, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction master request valid
- inst_wr  in  1  instruction master write (normally 0)
- inst_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- inst_wstrb  in  4  byte write strobes
- inst_addr  in  32  request address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction response valid this cycle
- inst_rdata  out  32  response data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request, same meanings as the inst_* inputs
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  data master accept and response
- mem_req  out  1  request to memory
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid; responses return strictly in order
- mem_rdata  in  32  response data
- ot_cnt  out  $clog2(OT_DEPTH)+1  outstanding request count

Behaviour:
- Reset clears: state = IDLE, ot_cnt = 0, queue pointers = 0, grant register = 0.
  - Every *_addr_ok, *_data_ok and mem_req output is 0 while reset is high and in the cycle after reset.
- Masters hold req and all request fields stable until they see addr_ok.
- full = (ot_cnt == OT_DEPTH).
- State IDLE:
  - sel = data if data_req, else inst (fixed priority: data over inst).
  - mem_req = (inst_req | data_req) & ~full; mem_* fields are muxed from sel.
  - If mem_req & mem_addr_ok: accept and stay in IDLE.
  - If mem_req & ~mem_addr_ok: latch sel into the grant register and go to HOLD.
- State HOLD:
  - mem_req = 1 and the mux is driven from the grant register. The grant must not switch even if the other master raises req (the slave may see the request change only after acceptance).
  - On mem_addr_ok: accept and return to IDLE.
- Accept (mem_req & mem_addr_ok):
  - Assert addr_ok for the granted master only, combinationally in the same cycle.
  - Push the master ID (0 = inst, 1 = data) into the queue at the write pointer.
- Response (mem_data_ok with ot_cnt > 0):
  - Pop the queue head and assert data_ok only for the head ID, same cycle.
  - mem_rdata is forwarded to both inst_rdata and data_rdata.
- mem_data_ok with ot_cnt == 0 is a protocol error: ignore it, assert no data_ok, counters unchanged.
- Counter update:
  - Push and pop in the same cycle: ot_cnt unchanged, both pointers advance.
  - Push only: +1. Pop only: −1.
- Pointers are log2(OT_DEPTH) bits and wrap naturally.
- Full handling:
  - While full, no new request is issued from IDLE.
  - A pop in that cycle does not unblock issue until the next cycle (conservative gate on registered ot_cnt).
  - HOLD is never entered while full, so the queue cannot overflow.
- Latency through the arbiter: zero cycles on both the request and response paths (pure mux plus queue lookup).
- Reset asserted mid-transaction discards all queue contents and the HOLD state; no data_ok is generated for lost requests.

Test Plan:
- Single inst read of 0x1c000000, mem_addr_ok in the same cycle, mem_data_ok 2 cycles later with rdata 0x02800000 -> inst_addr_ok in cycle 0; inst_data_ok with inst_rdata 0x02800000 in cycle 2; data_data_ok stays 0; ot_cnt goes 1 then 0.
- inst_req and data_req raised together (data write 0x1c008000, wstrb 4'hf) -> data accepted first (mem_wr = 1, mem_addr = 0x1c008000); inst accepted the next cycle; responses route data then inst.
- inst_req with mem_addr_ok held low 3 cycles, data_req raised in cycle 1 -> mem_addr stays at the inst address through HOLD; inst_addr_ok on acceptance; data is granted only afterwards.
- OT_DEPTH = 4: issue 5 inst reads with no mem_data_ok -> 4 accepted, ot_cnt = 4, mem_req = 0 for the 5th; one mem_data_ok -> 5th is issued the next cycle.
- Push and pop in the same cycle at ot_cnt = 2 -> ot_cnt stays 2; IDs stay in order across pointer wrap over 10 mixed transactions.
- Reset pulsed with 3 outstanding -> ot_cnt = 0; a later stray mem_data_ok produces no data_ok.
